// File: rtl/hazard_ctrl.sv
// Load-use / redirect hazard controller for the 5-stage core: drives NPC stall selects and pipeline register enables/flushes.
// Optional performance counters (and the CNT_W parameter) are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int unsigned CNT_W = 32)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_use,
  input  logic       id_rs2_use,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_redirect,
  input  logic       mem_wait,
  output logic       load_stall,
  output logic       branch_stall,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       idex_we,
  output logic       exmem_we,
  output logic       ifid_flush,
  output logic       idex_flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_lstall,
  output logic [CNT_W-1:0] cnt_flush
`endif
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_LSTALL = 2'd2;
  localparam logic [1:0] ST_FLUSH  = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       hz_c;

  // x0 never carries a real dependency, so a load to x0 cannot cause a stall
  always_comb begin
    hz_c = ex_is_load && (ex_rd != 5'd0) &&
           ((id_rs1_use && (id_rs1 == ex_rd)) || (id_rs2_use && (id_rs2 == ex_rd)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_stall   = 1'b0;
    branch_stall = 1'b0;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    if (mem_wait) begin
      // freeze: state held, decision re-evaluated once memory is ready
      load_stall = 1'b1;
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_we    = 1'b0;
      exmem_we   = 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          pc_we      = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_nxt  = ST_RUN;
        end
        ST_RUN, ST_LSTALL: begin
          state_nxt = ST_RUN;
          if (ex_redirect) begin
            branch_stall = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            state_nxt    = ST_FLUSH;
          end else if (hz_c && (state == ST_RUN)) begin
            // load has moved to MEM by the LSTALL cycle, so hz only matters in RUN
            load_stall = 1'b1;
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            state_nxt  = ST_LSTALL;
          end
        end
        ST_FLUSH: begin
          state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_BOOT;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_cycle  <= '0;
      cnt_lstall <= '0;
      cnt_flush  <= '0;
    end else begin
      if ((state != ST_BOOT) && (cnt_cycle != '1))
        cnt_cycle <= cnt_cycle + CNT_W'(1);
      if ((state == ST_RUN) && (state_nxt == ST_LSTALL) && (cnt_lstall != '1))
        cnt_lstall <= cnt_lstall + CNT_W'(1);
      if ((state != ST_FLUSH) && (state_nxt == ST_FLUSH) && (cnt_flush != '1))
        cnt_flush <= cnt_flush + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl: per-cycle table from reset plus hand-written reset/mem_wait corner sequences.
module tb_hazard_ctrl;

  // expected output word: {load_stall, branch_stall, pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush}
  localparam logic [7:0] O_BOOT = 8'b00011111;
  localparam logic [7:0] O_NORM = 8'b00111100;
  localparam logic [7:0] O_LST  = 8'b10001101;
  localparam logic [7:0] O_RDR  = 8'b01111111;
  localparam logic [7:0] O_WAIT = 8'b10000000;
  localparam int NV = 27;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       rdr;
    logic       mw;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_use, id_rs2_use, ex_is_load, ex_redirect, mem_wait;
  logic load_stall, branch_stall, pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cnt_cycle, cnt_lstall, cnt_flush;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .mem_wait(mem_wait),
    .load_stall(load_stall), .branch_stall(branch_stall),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush)
`ifdef HAZARD_PERF_CNT_EN
    , .cnt_cycle(cnt_cycle), .cnt_lstall(cnt_lstall), .cnt_flush(cnt_flush)
`endif
  );

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                              input logic u2, input logic [4:0] rd, input logic ld,
                              input logic rdr, input logic mw, input logic [7:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.ld = ld; v.rdr = rdr; v.mw = mw; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {load_stall, branch_stall, pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush};
  endfunction

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_use = v.u1; id_rs2_use = v.u2;
    ex_rd = v.rd; ex_is_load = v.ld; ex_redirect = v.rdr; mem_wait = v.mw;
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %b, expected %b", nm, idx, got, exp);
    end
  endtask

  vec_t idle, hz5, rdr1, mw1;

  initial begin
    idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    hz5  = mk(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 8'h00);
    rdr1 = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00);
    mw1  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 8'h00);

    // one entry per cycle starting with the BOOT cycle after reset release
    tbl[0]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_BOOT);
    tbl[1]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORM);
    tbl[2]  = mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, O_NORM);
    tbl[3]  = mk(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_LST);
    tbl[4]  = mk(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_NORM);
    tbl[5]  = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, O_NORM);
    tbl[6]  = mk(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, O_LST);
    tbl[7]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORM);
    tbl[8]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_RDR);
    tbl[9]  = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, O_NORM);
    tbl[10] = mk(5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, O_NORM);
    tbl[11] = mk(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, O_NORM);
    tbl[12] = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, O_RDR);
    tbl[13] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORM);
    tbl[14] = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, O_LST);
    tbl[15] = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, O_WAIT);
    tbl[16] = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, O_WAIT);
    tbl[17] = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, O_WAIT);
    tbl[18] = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, O_NORM);
    tbl[19] = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, O_LST);
    tbl[20] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_RDR);
    tbl[21] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_WAIT);
    tbl[22] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_NORM);
    tbl[23] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_WAIT);
    tbl[24] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_RDR);
    tbl[25] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORM);
    tbl[26] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORM);

    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", 0, 32'(outs()), 32'(O_BOOT));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check("vec", i, 32'(outs()), 32'(tbl[i].exp));
      @(posedge clk); #1;
    end

    // reset asserted in the middle of a load stall
    drive(hz5);
    @(negedge clk);
    check("rst_stall_pre", 0, 32'(outs()), 32'(O_LST));
    #2 rst_n = 1'b0;
    #1 check("rst_stall_async", 0, 32'(outs()), 32'(O_BOOT));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_stall_boot", 0, 32'(outs()), 32'(O_BOOT));
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_stall_run", 0, 32'(outs()), 32'(O_LST));
    @(posedge clk); #1;

    // now in LSTALL: redirect, then reset while in FLUSH
    drive(rdr1);
    @(negedge clk);
    check("lstall_redirect", 0, 32'(outs()), 32'(O_RDR));
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_mask", 0, 32'(outs()), 32'(O_NORM));
    #2 rst_n = 1'b0;
    #1 check("rst_flush_async", 0, 32'(outs()), 32'(O_BOOT));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_flush_boot", 0, 32'(outs()), 32'(O_BOOT));
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_flush_run", 0, 32'(outs()), 32'(O_RDR));
    @(posedge clk); #1;

    // mem_wait holds the BOOT state
    rst_n = 1'b0;
    drive(mw1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("boot_wait", 0, 32'(outs()), 32'(O_WAIT));
    @(posedge clk); #1;
    @(negedge clk);
    check("boot_wait", 1, 32'(outs()), 32'(O_WAIT));
    @(posedge clk); #1;
    drive(idle);
    @(negedge clk);
    check("boot_after_wait", 0, 32'(outs()), 32'(O_BOOT));
    @(posedge clk); #1;
    @(negedge clk);
    check("run_after_wait", 0, 32'(outs()), 32'(O_NORM));
    @(posedge clk); #1;

`ifdef HAZARD_PERF_CNT_EN
    // 20 cycles from reset: two load stalls and one redirect
    rst_n = 1'b0;
    drive(idle);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 2 || c == 4) drive(hz5);
      else if (c == 6)      drive(rdr1);
      else                  drive(idle);
      @(posedge clk); #1;
    end
    check("cnt_cycle", 0, cnt_cycle, 32'd19);
    check("cnt_lstall", 0, cnt_lstall, 32'd2);
    check("cnt_flush", 0, cnt_flush, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and redirect controller for the 5-stage RISC-V core. It watches the ID and EX stages and drives `load_stall` and `branch_stall` into the next-PC unit. It also drives the write-enable and flush controls of the PC, IF/ID and ID/EX pipeline registers. A small state machine guarantees exactly one bubble per load-use hazard and a two-slot squash per taken redirect, and it honours an external memory-wait freeze.

## Interface
Parameters:
- `CNT_W`, 32: width of the performance counters (used only with `PERF_CNT_EN`).

Ports (reset is asynchronous, active-low; the block has one clock):
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_rs1_use`, `id_rs2_use`  in  1 each  ID instruction actually reads rs1 / rs2.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_is_load`  in  1  EX instruction is a load.
- `ex_redirect`  in  1  EX instruction is a taken branch, jal or jalr. Target selection is done by the NPC unit.
- `mem_wait`  in  1  instruction or data memory not ready; freeze the whole pipeline.
- `load_stall`  out  1  to NPC: hold the PC.
- `branch_stall`  out  1  to NPC: take the redirect target computed from the EX PC.
- `pc_we`, `ifid_we`, `idex_we`, `exmem_we`  out  1 each  pipeline register enables.
- `ifid_flush`, `idex_flush`  out  1 each  synchronous bubble insert on the next edge.
- `cnt_cycle`, `cnt_lstall`, `cnt_flush`  out  CNT_W each  performance counters (`PERF_CNT_EN` only).

## Operation
- States: BOOT, RUN, LSTALL, FLUSH. Reset enters BOOT.
- **BOOT** (one cycle after reset release):
  - Outputs: `pc_we=0`, `ifid_flush=1`, `idex_flush=1`.
  - Next state: RUN.
- **Hazard definition** (`hz`):
  - `hz = ex_is_load & ex_rd != 0 & ((id_rs1_use & id_rs1 == ex_rd) | (id_rs2_use & id_rs2 == ex_rd))`.
- **RUN**, in priority order (`mem_wait` is highest and is covered below):
  - `ex_redirect`:
    - Outputs: `branch_stall=1`, `ifid_flush=1`, `idex_flush=1`, all write-enables 1.
    - Next state: FLUSH.
  - `hz`:
    - Outputs: `load_stall=1`, `pc_we=0`, `ifid_we=0`, `idex_flush=1`.
    - Next state: LSTALL.
  - Otherwise: all write-enables 1, no flush.
- **LSTALL**:
  - Outputs: normal advance. `hz` is ignored for this cycle because the load is now in MEM.
  - Next state: RUN. A new `ex_redirect` in this cycle is handled exactly as in RUN (next state FLUSH).
- **FLUSH**:
  - The squashed slot is in EX, so `ex_redirect` and `hz` are masked.
  - Outputs: normal advance.
  - Next state: RUN.
- **`mem_wait=1`** in any state:
  - Outputs: all write-enables 0, all flushes 0, `load_stall=1`, `branch_stall=0`.
  - State is held; the pending decision is re-evaluated when `mem_wait` falls.
- `ex_redirect` and `hz` cannot both be true legitimately. If they are, redirect wins.

## Timing
- `load_stall`, `branch_stall`, all write-enables and all flushes are combinational from the current state and inputs. They are valid in the same cycle, so NPC selects that cycle.
- The state register updates on the rising edge of `clk`.
- Reset values (state BOOT):
  - `load_stall=0`, `branch_stall=0`.
  - `pc_we=0`, `ifid_we=1`, `idex_we=1`, `exmem_we=1`.
  - `ifid_flush=1`, `idex_flush=1`.
  - All counters 0.
- Latencies:
  - Load-use hazard: exactly 1 bubble.
  - Taken redirect: exactly 2 squashed slots; the first correct-path instruction is fetched the cycle after `branch_stall`.
- Reset asserted mid-stall or mid-flush: immediate return to BOOT. No pending stall survives.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `cnt_cycle` increments every non-BOOT cycle.
  - `cnt_lstall` increments on each RUN→LSTALL transition.
  - `cnt_flush` increments on each →FLUSH transition.
  - All three saturate at all-ones and are cleared only by `rst_n`.
- Not defined: the counter ports are absent and no counter logic is built. Stall and flush behaviour is identical in both builds.

## Test plan
- Reset release, no hazards:
  - Cycle 0: `pc_we=0` and both flushes 1.
  - Cycle 1 onward: `pc_we=1`, `load_stall=0`, `branch_stall=0`.
- EX `lw x5` (`ex_rd=5`, `ex_is_load=1`) with ID `add x6,x5,x7` (`id_rs1=5`, `id_rs1_use=1`):
  - That cycle: `load_stall=1`, `pc_we=0`, `ifid_we=0`, `idex_flush=1`.
  - Next cycle: normal advance with `load_stall=0`, even if the inputs are held.
- EX load with `ex_rd=0` matching `id_rs1=0` -> no stall.
- `ex_redirect=1` in RUN:
  - That cycle: `branch_stall=1` and both flushes 1.
  - Next cycle, with `ex_redirect` held 1: FLUSH state and `branch_stall=0`.
- `mem_wait=1` for 3 cycles during LSTALL:
  - Those cycles: all write-enables 0, and the state stays LSTALL.
  - After `mem_wait` falls: one normal advance, then RUN.
- With `HAZARD_PERF_CNT_EN`, 2 load stalls and 1 redirect in 20 cycles -> `cnt_lstall=2`, `cnt_flush=1`, `cnt_cycle=19`.
